id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode->Execute pipeline register fed by registerFile read ports and decoder controls.
//  Captures operands, immediate, register indices and control bits once per cycle.
//  Detects load-use hazards and inserts a bubble.
//  Honours downstream stall and branch flush.
// PARAMETERS
//  XLEN     32  datapath width (pc, operands, immediate)
//  ALUOP_W  4   width of ALU operation code
// PORTS
//  clock            in   1        rising-edge clock, sole clock domain
//  reset            in   1        asynchronous, active-low; clears all state
//  stall            in   1        downstream hold: keep current contents
//  flush            in   1        branch/jump redirect: kill the stage contents
//  inValid          in   1        decode slot holds a real instruction
//  inPc             in   XLEN     PC of the decoding instruction
//  inReadData1/2    in   XLEN     registerFile readData1/readData2
//  inImm            in   XLEN     sign-extended immediate
//  inRs1/inRs2/inRd in   5        register indices
//  inAluOp          in   ALUOP_W  ALU operation
//  inAluSrc, inMemRead, inMemWrite, inRegisterWrite, inMemToReg  in 1  control bits
//  wbRd             in   5        writeback destination (bypass only)
//  wbData           in   XLEN     writeback data (bypass only)
//  wbRegisterWrite  in   1        writeback enable (bypass only)
//  loadUseStall     out  1        combinational: freeze PC and IF/ID this cycle
//  out*             out  -        registered copies of every in* field plus outValid
// BEHAVIOUR
//  - Reset (reset==0, async): outValid=0; every out* data, index and control field = 0.
//  - Latency: 1 cycle; a field presented at edge N appears at out* after edge N.
//  - loadUseStall = outValid & outMemRead & (outRd!=0) & inValid &
//    ((outRd==inRs1) | (outRd==inRs2)). Combinational from registered state.
//  - Priority at each posedge, highest first:
//    1. flush: outValid=0; control bits (MemRead, MemWrite, RegisterWrite, MemToReg) = 0.
//       Data fields are don't-care.
//    2. stall: all out* hold. A pending loadUseStall remains asserted.
//    3. loadUseStall: insert a bubble (same effect as flush). Upstream holds the
//       instruction, so it is recaptured next cycle once the hazard clears.
//    4. Otherwise capture all in*.
//       inValid=0 -> outValid=0 and control bits forced to 0.
//  - Hazard detection ignores x0: outRd==0 never asserts loadUseStall.
//  - A bubble is never itself a hazard source, because outValid=0.
//  - flush together with stall: flush wins.
//  - reset deasserted mid-stall: the stage comes up empty; stall then holds the empty state.
// CONFIGURATION
//  Macro ID_WB_BYPASS_EN:
//  - Defined: during capture, if wbRegisterWrite & (wbRd!=0) & (wbRd==inRs1),
//    outReadData1 <= wbData. Same rule for rs2 -> outReadData2.
//    This covers registerFile write-then-read in the same cycle.
//  - Undefined: wb* ports are present but ignored; operands are taken verbatim.
//    Decode must then avoid same-cycle WB/ID collisions.
// STRUCTURE
//  - Shared package core_pkg: XLEN, ALUOP_W, ALU opcode localparams, REG_X0=5'd0.
//  - Also in core_pkg: control-bundle field order, shared with ex_mem_stage.
//  - One sub-module, load_use_detect (pure combinational comparator).
//  - Pipeline register flops live in id_ex_stage itself.
// TESTING
//  1. Hold reset=0, toggle the inputs -> all out* = 0 and loadUseStall = 0 throughout.
//  2. Apply inRd=5, inReadData1=32'h1234, inAluOp=4'h2, inValid=1 ->
//     the next cycle shows outRd=5, outReadData1=32'h1234, outValid=1.
//  3. Stage holds lw x5 (outMemRead=1, outRd=5); apply inRs2=5 -> loadUseStall=1.
//     Next edge: outValid=0, outRegisterWrite=0. Following edge: the instruction
//     is captured, loadUseStall=0.
//  4. Assert stall=1 for 3 cycles with changing inputs -> out* are unchanged.
//     Add flush=1 during the stall -> outValid=0 on the next edge.
//  5. Stage holds lw x0 with inRs1=0 -> loadUseStall stays 0.
//  6. ID_WB_BYPASS_EN defined: wbRd=7, wbData=32'hCAFE, wbRegisterWrite=1,
//     inRs1=7, inReadData1=0 -> outReadData1=32'hCAFE.
//     Same stimulus with the macro undefined -> outReadData1=0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, ALU opcodes and the ID/EX control bundle
package core_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'h8;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'h9;

    // Field order is shared with ex_mem_stage; keep both in step.
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               register_write;
        logic               mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A killed slot must not touch memory or the register file.
    function automatic ctrl_t kill_ctrl(input ctrl_t c);
        ctrl_t k;
        k                = c;
        k.mem_read       = 1'b0;
        k.mem_write      = 1'b0;
        k.register_write = 1'b0;
        k.mem_to_reg     = 1'b0;
        return k;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
    import core_pkg::*;
(
    input  logic       exValid,
    input  logic       exMemRead,
    input  logic [4:0] exRd,
    input  logic       idValid,
    input  logic [4:0] idRs1,
    input  logic [4:0] idRs2,
    output logic       hazard
);

    // A load in EX whose destination is read by the instruction in ID; x0 never counts.
    always_comb begin
        hazard = exValid && exMemRead && (exRd != REG_X0) && idValid &&
                 ((exRd == idRs1) || (exRd == idRs2));
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble; optional WB bypass via ID_WB_BYPASS_EN
module id_ex_stage
    import core_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               inValid,
    input  logic [XLEN-1:0]    inPc,
    input  logic [XLEN-1:0]    inReadData1,
    input  logic [XLEN-1:0]    inReadData2,
    input  logic [XLEN-1:0]    inImm,
    input  logic [4:0]         inRs1,
    input  logic [4:0]         inRs2,
    input  logic [4:0]         inRd,
    input  logic [ALUOP_W-1:0] inAluOp,
    input  logic               inAluSrc,
    input  logic               inMemRead,
    input  logic               inMemWrite,
    input  logic               inRegisterWrite,
    input  logic               inMemToReg,
    input  logic [4:0]         wbRd,
    input  logic [XLEN-1:0]    wbData,
    input  logic               wbRegisterWrite,
    output logic               loadUseStall,
    output logic               outValid,
    output logic [XLEN-1:0]    outPc,
    output logic [XLEN-1:0]    outReadData1,
    output logic [XLEN-1:0]    outReadData2,
    output logic [XLEN-1:0]    outImm,
    output logic [4:0]         outRs1,
    output logic [4:0]         outRs2,
    output logic [4:0]         outRd,
    output logic [ALUOP_W-1:0] outAluOp,
    output logic               outAluSrc,
    output logic               outMemRead,
    output logic               outMemWrite,
    output logic               outRegisterWrite,
    output logic               outMemToReg
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rd1_q, rd1_d;
    logic [XLEN-1:0] rd2_q, rd2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;
    ctrl_t           in_ctrl;
    logic [XLEN-1:0] op1, op2;

    assign in_ctrl = '{alu_op: inAluOp, alu_src: inAluSrc, mem_read: inMemRead,
                       mem_write: inMemWrite, register_write: inRegisterWrite,
                       mem_to_reg: inMemToReg};

    load_use_detect u_load_use_detect (
        .exValid   (valid_q),
        .exMemRead (ctrl_q.mem_read),
        .exRd      (rd_q),
        .idValid   (inValid),
        .idRs1     (inRs1),
        .idRs2     (inRs2),
        .hazard    (loadUseStall)
    );

`ifdef ID_WB_BYPASS_EN
    // Forward a same-cycle writeback so a register written this cycle is read fresh.
    always_comb begin
        op1 = inReadData1;
        op2 = inReadData2;
        if (wbRegisterWrite && (wbRd != REG_X0) && (wbRd == inRs1)) op1 = wbData;
        if (wbRegisterWrite && (wbRd != REG_X0) && (wbRd == inRs2)) op2 = wbData;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wbRd, wbData, wbRegisterWrite};
    assign op1 = inReadData1;
    assign op2 = inReadData2;
`endif

    // Next state: flush beats stall, stall beats the load-use bubble, else capture.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush || (!stall && loadUseStall)) begin
            valid_d = 1'b0;
            ctrl_d  = kill_ctrl(ctrl_q);
        end else if (!stall) begin
            valid_d = inValid;
            pc_d    = inPc;
            rd1_d   = op1;
            rd2_d   = op2;
            imm_d   = inImm;
            rs1_d   = inRs1;
            rs2_d   = inRs2;
            rd_d    = inRd;
            ctrl_d  = inValid ? in_ctrl : kill_ctrl(in_ctrl);
        end
    end

    // Pipeline register; reset empties the stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign outValid         = valid_q;
    assign outPc            = pc_q;
    assign outReadData1     = rd1_q;
    assign outReadData2     = rd2_q;
    assign outImm           = imm_q;
    assign outRs1           = rs1_q;
    assign outRs2           = rs2_q;
    assign outRd            = rd_q;
    assign outAluOp         = ctrl_q.alu_op;
    assign outAluSrc        = ctrl_q.alu_src;
    assign outMemRead       = ctrl_q.mem_read;
    assign outMemWrite      = ctrl_q.mem_write;
    assign outRegisterWrite = ctrl_q.register_write;
    assign outMemToReg      = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - vector-table bench for id_ex_stage
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush, inValid;
    logic [31:0] inPc, inReadData1, inReadData2, inImm, wbData;
    logic [4:0]  inRs1, inRs2, inRd, wbRd;
    logic [3:0]  inAluOp;
    logic        inAluSrc, inMemRead, inMemWrite, inRegisterWrite, inMemToReg, wbRegisterWrite;
    logic        loadUseStall, outValid;
    logic [31:0] outPc, outReadData1, outReadData2, outImm;
    logic [4:0]  outRs1, outRs2, outRd;
    logic [3:0]  outAluOp;
    logic        outAluSrc, outMemRead, outMemWrite, outRegisterWrite, outMemToReg;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .inValid(inValid),
        .inPc(inPc), .inReadData1(inReadData1), .inReadData2(inReadData2), .inImm(inImm),
        .inRs1(inRs1), .inRs2(inRs2), .inRd(inRd), .inAluOp(inAluOp), .inAluSrc(inAluSrc),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inRegisterWrite(inRegisterWrite),
        .inMemToReg(inMemToReg), .wbRd(wbRd), .wbData(wbData), .wbRegisterWrite(wbRegisterWrite),
        .loadUseStall(loadUseStall), .outValid(outValid), .outPc(outPc),
        .outReadData1(outReadData1), .outReadData2(outReadData2), .outImm(outImm),
        .outRs1(outRs1), .outRs2(outRs2), .outRd(outRd), .outAluOp(outAluOp),
        .outAluSrc(outAluSrc), .outMemRead(outMemRead), .outMemWrite(outMemWrite),
        .outRegisterWrite(outRegisterWrite), .outMemToReg(outMemToReg)
    );

    typedef struct packed {
        logic        st, fl, v;
        logic [4:0]  rs1, rs2, rd;
        logic        mr, rw;
        logic [31:0] d1;
        logic        lus, ov;
        logic [4:0]  ord;
        logic        omr, orw;
        logic [31:0] od1;
        logic        chkd;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic st, fl, v, input logic [4:0] rs1, rs2, rd,
                                input logic mr, rw, input logic [31:0] d1,
                                input logic lus, ov, input logic [4:0] ord,
                                input logic omr, orw, input logic [31:0] od1, input logic chkd);
        vec_t r;
        r.st = st; r.fl = fl; r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.mr = mr; r.rw = rw; r.d1 = d1; r.lus = lus; r.ov = ov; r.ord = ord;
        r.omr = omr; r.orw = orw; r.od1 = od1; r.chkd = chkd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, fl, v, input logic [4:0] rs1, rs2, rd,
                         input logic mr, rw, input logic [31:0] d1);
        stall = st; flush = fl; inValid = v; inRs1 = rs1; inRs2 = rs2; inRd = rd;
        inMemRead = mr; inRegisterWrite = rw; inReadData1 = d1;
        inReadData2 = d1 ^ 32'h0000_FFFF; inImm = d1 + 32'd1; inPc = {d1[15:0], 16'h0};
        inAluOp = rd[3:0]; inAluSrc = rd[0]; inMemWrite = 1'b0; inMemToReg = mr;
    endtask

    initial begin
        logic [31:0] exp_byp;
        reset = 1'b0;
        wbRd = 5'd0; wbData = 32'd0; wbRegisterWrite = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'd0);

        // Reset held: outputs stay zero while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            drive(1'(i == 2), 0, 1, 5'd5, 5'd5, 5'd5, 1, 1, 32'hDEAD_0000 + 32'(i));
            step();
            chk($sformatf("reset_outs_%0d", i),
                {31'd0, |{outValid, outPc, outReadData1, outReadData2, outImm, outRs1, outRs2,
                          outRd, outAluOp, outAluSrc, outMemRead, outMemWrite,
                          outRegisterWrite, outMemToReg}}, 32'd0);
            chk($sformatf("reset_lus_%0d", i), {31'd0, loadUseStall}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        step();

        // Plain capture with every field checked.
        drive(0, 0, 1, 5'd3, 5'd4, 5'd5, 0, 1, 32'h1234);
        inAluOp = 4'h2; inAluSrc = 1'b1; inMemWrite = 1'b1; inMemToReg = 1'b1;
        inPc = 32'h0000_0400; inImm = 32'hFFFF_FFF0; inReadData2 = 32'h5678;
        step();
        chk("cap_valid", {31'd0, outValid}, 32'd1);
        chk("cap_rd", {27'd0, outRd}, 32'd5);
        chk("cap_rs1", {27'd0, outRs1}, 32'd3);
        chk("cap_rs2", {27'd0, outRs2}, 32'd4);
        chk("cap_d1", outReadData1, 32'h1234);
        chk("cap_d2", outReadData2, 32'h5678);
        chk("cap_pc", outPc, 32'h0000_0400);
        chk("cap_imm", outImm, 32'hFFFF_FFF0);
        chk("cap_aluop", {28'd0, outAluOp}, 32'h2);
        chk("cap_ctrl", {27'd0, outAluSrc, outMemRead, outMemWrite, outRegisterWrite, outMemToReg},
            32'b10111);

        vt[0]  = mk(0,0,1, 1, 2, 5, 0,1,32'h1234, 0,1, 5,0,1,32'h1234,1);
        vt[1]  = mk(0,0,1, 3, 4, 5, 1,1,32'h1111, 0,1, 5,1,1,32'h1111,1);
        vt[2]  = mk(0,0,1, 1, 5, 6, 0,1,32'h2222, 1,0, 0,0,0,32'h0,   0);
        vt[3]  = mk(0,0,1, 1, 5, 6, 0,1,32'h2222, 0,1, 6,0,1,32'h2222,1);
        vt[4]  = mk(1,0,1, 9, 9, 9, 1,1,32'h3333, 0,1, 6,0,1,32'h2222,1);
        vt[5]  = mk(1,0,1,10,10,10, 1,0,32'h4444, 0,1, 6,0,1,32'h2222,1);
        vt[6]  = mk(1,0,1,11, 6,11, 0,1,32'h4545, 0,1, 6,0,1,32'h2222,1);
        vt[7]  = mk(1,1,1,11, 6,11, 1,1,32'h4646, 0,0, 0,0,0,32'h0,   0);
        vt[8]  = mk(0,0,1, 0, 0, 0, 1,1,32'h5555, 0,1, 0,1,1,32'h5555,1);
        vt[9]  = mk(0,0,1, 0, 0, 7, 0,1,32'h6666, 0,1, 7,0,1,32'h6666,1);
        vt[10] = mk(0,0,1, 1, 2, 7, 1,1,32'h7777, 0,1, 7,1,1,32'h7777,1);
        vt[11] = mk(1,0,1, 7, 3, 8, 0,1,32'h8888, 1,1, 7,1,1,32'h7777,1);
        vt[12] = mk(0,0,1, 7, 3, 8, 0,1,32'h8888, 1,0, 0,0,0,32'h0,   0);
        vt[13] = mk(0,0,1, 7, 3, 8, 0,1,32'h8888, 0,1, 8,0,1,32'h8888,1);
        vt[14] = mk(0,0,0, 1, 2,12, 1,1,32'h9999, 0,0,12,0,0,32'h9999,1);
        vt[15] = mk(0,0,1,12,12,13, 0,0,32'hAAAA, 0,1,13,0,0,32'hAAAA,1);
        vt[16] = mk(0,1,1,13, 1,14, 0,1,32'hBBBB, 0,0, 0,0,0,32'h0,   0);

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].st, vt[i].fl, vt[i].v, vt[i].rs1, vt[i].rs2, vt[i].rd,
                  vt[i].mr, vt[i].rw, vt[i].d1);
            #1;
            chk($sformatf("v%0d_lus", i), {31'd0, loadUseStall}, {31'd0, vt[i].lus});
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, outValid}, {31'd0, vt[i].ov});
            chk($sformatf("v%0d_memread", i), {31'd0, outMemRead}, {31'd0, vt[i].omr});
            chk($sformatf("v%0d_regwrite", i), {31'd0, outRegisterWrite}, {31'd0, vt[i].orw});
            if (vt[i].chkd) begin
                chk($sformatf("v%0d_rd", i), {27'd0, outRd}, {27'd0, vt[i].ord});
                chk($sformatf("v%0d_d1", i), outReadData1, vt[i].od1);
            end
        end

        // Writeback bypass into both operands.
`ifdef ID_WB_BYPASS_EN
        exp_byp = 32'hCAFE;
`else
        exp_byp = 32'h0;
`endif
        drive(0, 0, 1, 5'd7, 5'd7, 5'd9, 0, 1, 32'h0);
        inReadData2 = 32'h0;
        wbRd = 5'd7; wbData = 32'hCAFE; wbRegisterWrite = 1'b1;
        step();
        chk("byp_d1", outReadData1, exp_byp);
        chk("byp_d2", outReadData2, exp_byp);
        wbRegisterWrite = 1'b0; inReadData1 = 32'h11;
        step();
        chk("byp_off_d1", outReadData1, 32'h11);
        wbRd = 5'd0; wbRegisterWrite = 1'b1; inRs1 = 5'd0; inReadData1 = 32'h55;
        step();
        chk("byp_x0_d1", outReadData1, 32'h55);
        wbRegisterWrite = 1'b0;

        // Asynchronous reset during a stall, then stall holds the empty stage.
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, outValid}, 32'd0);
        chk("async_rst_rd", {27'd0, outRd}, 32'd0);
        chk("async_rst_d1", outReadData1, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 0, 1, 5'd1, 5'd2, 5'd3, 0, 1, 32'h77);
        step();
        chk("stall_after_rst_valid", {31'd0, outValid}, 32'd0);
        chk("stall_after_rst_rd", {27'd0, outRd}, 32'd0);
        stall = 1'b0;
        step();
        chk("resume_valid", {31'd0, outValid}, 32'd1);
        chk("resume_rd", {27'd0, outRd}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
